// File: rtl/paper_cpu_sequencer.sv
// Fetch/execute controller for the paper processor: INC / JNO / HLT against an accumulator.
// Optional single-step gating of FETCH via PAPER_CPU_SINGLE_STEP_EN (adds the step input).
module paper_cpu_sequencer #(
  parameter int unsigned ACC_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
`ifdef PAPER_CPU_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [1:0]            instr_data,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  ovf,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  illegal
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StOperand, StHalt} state_e;

  localparam logic [1:0] OpInc = 2'b00;
  localparam logic [1:0] OpJno = 2'b01;
  localparam logic [1:0] OpHlt = 2'b10;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic                    halted_q, halted_d;
  logic                    illegal_q, illegal_d;
  logic [1:0]              ir_q, ir_d;
  logic [ACC_WIDTH:0]      acc_inc;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic                    fetch_go;

  assign acc_inc = {1'b0, acc_q} + (ACC_WIDTH+1)'(1);
  assign pc_inc  = pc_q + ADDR_WIDTH'(1);

`ifdef PAPER_CPU_SINGLE_STEP_EN
  assign fetch_go = run & step;
`else
  assign fetch_go = run;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    ir_d      = ir_q;
    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (fetch_go) begin
          ir_d    = instr_data;
          pc_d    = pc_inc;
          state_d = StExec;
        end
      end
      StExec: begin
        case (ir_q)
          OpInc: begin
            acc_d   = acc_inc[ACC_WIDTH-1:0];
            ovf_d   = acc_inc[ACC_WIDTH];
            state_d = StFetch;
          end
          OpJno: state_d = StOperand;
          OpHlt: begin
            halted_d = 1'b1;
            state_d  = StHalt;
          end
          default: begin
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = StHalt;
          end
        endcase
      end
      StOperand: begin
        // Taken jump loads the operand; otherwise step over the operand word.
        pc_d    = ovf_q ? pc_inc : ADDR_WIDTH'(instr_data);
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      ir_q      <= 2'b00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      ir_q      <= ir_d;
    end
  end

  assign instr_addr = pc_q;
  assign pc         = pc_q;
  assign acc        = acc_q;
  assign ovf        = ovf_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_paper_cpu_sequencer.sv
// Directed self-checking bench for paper_cpu_sequencer with a combinational 4-word store.
// Exercises the single-step path too when PAPER_CPU_SINGLE_STEP_EN is defined.
module tb_paper_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [1:0] instr_addr;
  logic [1:0] instr_data;
  logic [3:0] acc;
  logic       ovf;
  logic [1:0] pc;
  logic       halted;
  logic       illegal;
  logic [1:0] mem [4];

  int checks   = 0;
  int failures = 0;

`ifdef PAPER_CPU_SINGLE_STEP_EN
  logic step;
`endif

  always #5 clk = ~clk;

  assign instr_data = mem[instr_addr];

  paper_cpu_sequencer #(
    .ACC_WIDTH (4),
    .ADDR_WIDTH(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
`ifdef PAPER_CPU_SINGLE_STEP_EN
    .step      (step),
`endif
    .instr_addr(instr_addr),
    .instr_data(instr_data),
    .acc       (acc),
    .ovf       (ovf),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_loop_prog();
    mem[0] = 2'b00;
    mem[1] = 2'b01;
    mem[2] = 2'b00;
    mem[3] = 2'b10;
  endtask

  initial begin
`ifdef PAPER_CPU_SINGLE_STEP_EN
    step = 1'b1;
`endif
    load_loop_prog();
    do_reset();
    check("rst_pc", 32'(pc), 0);
    check("rst_addr", 32'(instr_addr), 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_illegal", 32'(illegal), 0);

    // Counting loop: 16 INCs wrap acc, JNO falls through to HLT at edge 83.
    run = 1'b1;
    for (int e = 1; e <= 83; e++) begin
      tick();
      if (e == 3) begin
        check("loop_acc1", 32'(acc), 1);
        check("loop_ovf0", 32'(ovf), 0);
      end
      if (e == 78) begin
        check("loop_wrap_acc", 32'(acc), 0);
        check("loop_wrap_ovf", 32'(ovf), 1);
      end
      if (e == 82) check("loop_halt_e82", 32'(halted), 0);
    end
    check("loop_halted", 32'(halted), 1);
    check("loop_acc", 32'(acc), 0);
    check("loop_ovf", 32'(ovf), 1);
    check("loop_illegal", 32'(illegal), 0);
    check("loop_pc_wrap", 32'(pc), 0);

    // Immediate HLT.
    mem[0] = 2'b10;
    do_reset();
    run = 1'b1;
    tick();
    tick();
    check("hlt_e2", 32'(halted), 0);
    tick();
    check("hlt_halted", 32'(halted), 1);
    check("hlt_pc", 32'(pc), 1);
    check("hlt_acc", 32'(acc), 0);
    check("hlt_ovf", 32'(ovf), 0);
    check("hlt_illegal", 32'(illegal), 0);

    // Illegal opcode, then HALT must be absorbing with run toggling.
    mem[0] = 2'b11;
    do_reset();
    run = 1'b1;
    tick();
    tick();
    tick();
    check("ill_halted", 32'(halted), 1);
    check("ill_illegal", 32'(illegal), 1);
    check("ill_acc", 32'(acc), 0);
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      tick();
    end
    check("ill_hold_pc", 32'(pc), 1);
    check("ill_hold_halted", 32'(halted), 1);
    check("ill_hold_illegal", 32'(illegal), 1);
    check("ill_hold_acc", 32'(acc), 0);

    // Pause in FETCH for 10 cycles after the first INC.
    load_loop_prog();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pause_acc", 32'(acc), 1);
    check("pause_pc", 32'(pc), 1);
    check("pause_halted", 32'(halted), 0);
    run = 1'b1;
    for (int i = 0; i < 79; i++) tick();
    check("pause_e92", 32'(halted), 0);
    tick();
    check("pause_halted_e93", 32'(halted), 1);
    check("pause_acc_fin", 32'(acc), 0);
    check("pause_ovf_fin", 32'(ovf), 1);

    // Reset during OPERAND with acc=5 (edge 25), then a clean rerun.
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    check("mid_acc5", 32'(acc), 5);
    check("mid_pc", 32'(pc), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_acc", 32'(acc), 0);
    check("mid_rst_pc", 32'(pc), 0);
    check("mid_rst_ovf", 32'(ovf), 0);
    for (int i = 0; i < 82; i++) tick();
    check("rerun_e82", 32'(halted), 0);
    tick();
    check("rerun_halted", 32'(halted), 1);
    check("rerun_acc", 32'(acc), 0);
    check("rerun_ovf", 32'(ovf), 1);

`ifdef PAPER_CPU_SINGLE_STEP_EN
    // One instruction per step pulse; IDLE->FETCH does not need step.
    do_reset();
    run  = 1'b1;
    step = 1'b0;
    tick();
    for (int p = 1; p <= 4; p++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      tick();
      tick();
      if (p == 1) check("step_inc1", 32'(acc), 1);
      if (p == 2) check("step_jno_pc", 32'(pc), 0);
      if (p == 3) check("step_inc2", 32'(acc), 2);
      if (p == 4) check("step_jno_acc", 32'(acc), 2);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
